// File: rtl/alu_disp_pkg.sv
// Shared constants for the ALU result display: segment patterns, anode patterns, digit codes.
// Signed display is selected by defining ALU_DISP_SIGNED_EN.
package alu_disp_pkg;

  localparam int DIGIT_CYCLES_DEF = 100000;
  localparam int CNT_W            = 20;

  typedef enum logic [1:0] {
    DIG_ONES = 2'd0,
    DIG_TENS = 2'd1,
    DIG_SIGN = 2'd2,
    DIG_FXN  = 2'd3
  } digit_e;

  // Active-low cathodes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_MINUS = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [3:0] AN_SIGN = 4'b1011;
  localparam logic [3:0] AN_FXN  = 4'b0111;

  function automatic logic [3:0] anode_for(digit_e d);
    logic [3:0] a;
    case (d)
      DIG_ONES: a = AN_ONES;
      DIG_TENS: a = AN_TENS;
      DIG_SIGN: a = AN_SIGN;
      default:  a = AN_FXN;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/alu_result_display_seg7_decoder.sv
// Combinational 7-segment decoder: codes 0..9 are digits, 10 is minus, anything else blank.
module seg7_decoder
  import alu_disp_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      4'd0:       seg_o = SEG_DIGIT[0];
      4'd1:       seg_o = SEG_DIGIT[1];
      4'd2:       seg_o = SEG_DIGIT[2];
      4'd3:       seg_o = SEG_DIGIT[3];
      4'd4:       seg_o = SEG_DIGIT[4];
      4'd5:       seg_o = SEG_DIGIT[5];
      4'd6:       seg_o = SEG_DIGIT[6];
      4'd7:       seg_o = SEG_DIGIT[7];
      4'd8:       seg_o = SEG_DIGIT[8];
      4'd9:       seg_o = SEG_DIGIT[9];
      CODE_MINUS: seg_o = SEG_MINUS;
      default:    seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/alu_result_display.sv
// Multiplexed 4-digit display of a captured 6-bit ALU result and its function code.
// Define ALU_DISP_SIGNED_EN to show the result as two's complement (-32..31).
module alu_result_display
  import alu_disp_pkg::*;
#(
  parameter int DIGIT_CYCLES = DIGIT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] X,
  input  logic [2:0] fxn,
  input  logic       load,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_e           dig_q, dig_d;
  logic [5:0]       x_q, x_d;
  logic [2:0]       f_q, f_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;

  logic             neg;
  logic [5:0]       mag;
  logic [3:0]       tens, ones, code;

  always_comb begin
    x_d = x_q;
    f_d = f_q;
    if (load) begin
      x_d = X;
      f_d = fxn;
    end
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    dig_d = dig_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      dig_d = digit_e'(dig_q + 2'd1);
    end
  end

  // Magnitude of -32 is 100000, which still fits 6 bits unsigned
  always_comb begin
`ifdef ALU_DISP_SIGNED_EN
    neg = x_q[5];
    mag = neg ? (~x_q + 6'd1) : x_q;
`else
    neg = 1'b0;
    mag = x_q;
`endif
    tens = 4'(mag / 6'd10);
    ones = 4'(mag % 6'd10);
  end

  // seg and an are both computed from the upcoming digit so they switch on the same edge
  always_comb begin
    code = CODE_BLANK;
    case (dig_d)
      DIG_ONES: code = ones;
      DIG_TENS: code = (tens == 4'd0) ? CODE_BLANK : tens;
      DIG_SIGN: code = neg ? CODE_MINUS : CODE_BLANK;
      default:  code = {1'b0, f_q};
    endcase
    an_d = anode_for(dig_d);
  end

  seg7_decoder u_dec (
    .code_i (code),
    .seg_o  (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      dig_q <= DIG_ONES;
      x_q   <= '0;
      f_q   <= '0;
      seg_q <= SEG_DIGIT[0];
      an_q  <= AN_ONES;
    end else begin
      cnt_q <= cnt_d;
      dig_q <= dig_d;
      x_q   <= x_d;
      f_q   <= f_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_alu_result_display.sv
// Self-checking bench for alu_result_display with DIGIT_CYCLES=4; model follows ALU_DISP_SIGNED_EN.
module tb_alu_result_display;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [5:0] X = '0;
  logic [2:0] fxn = '0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;

  logic [6:0] disp [4];

  alu_result_display #(.DIGIT_CYCLES(DC)) dut (
    .clk  (clk),
    .rst  (rst),
    .X    (X),
    .fxn  (fxn),
    .load (load),
    .seg  (seg),
    .an   (an),
    .dp   (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: interpret value, split magnitude into decimal digits, pick pattern per position
  function automatic logic [6:0] exp_seg(input int dig, input int x, input int f);
    int  v, m;
    bit  neg;
    logic [6:0] r;
`ifdef ALU_DISP_SIGNED_EN
    v = (x >= 32) ? x - 64 : x;
`else
    v = x;
`endif
    neg = (v < 0);
    m   = neg ? -v : v;
    case (dig)
      0:       r = seg_tab[m % 10];
      1:       r = (m / 10 == 0) ? BLANK : seg_tab[m / 10];
      2:       r = neg ? MINUS : BLANK;
      default: r = seg_tab[f];
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      check("an_onehot", 32'($countones(~an)), 32'd1);
      check("dp_off", {31'd0, dp}, 32'd1);
    end
  end

  task automatic read_disp();
    int w;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (an !== an_tab[k] && w < 40) begin
        @(negedge clk);
        w++;
      end
      if (w >= 40) check("scan_timeout", 32'd0, 32'd1);
      disp[k] = seg;
    end
  endtask

  task automatic expect_disp(input string tag, input int x, input int f);
    read_disp();
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_d%0d", tag, k), {25'd0, disp[k]}, {25'd0, exp_seg(k, x, f)});
  endtask

  task automatic do_load(input logic [5:0] x, input logic [2:0] f);
    @(negedge clk);
    X = x;
    fxn = f;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic count_until_leave_ones(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (an === 4'b1110 && n < 40);
    check(tag, n, exp_n);
    check({tag, "_an"}, {28'd0, an}, 32'h0000000d);
  endtask

  initial begin
    int n;
    logic [5:0] rx;
    logic [2:0] rf;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    check("rst_an", {28'd0, an}, 32'h0000000e);
    check("rst_seg", {25'd0, seg}, 32'h00000040);
    check("rst_dp", {31'd0, dp}, 32'd1);

    rst = 1'b0;
    count_until_leave_ones("first_switch", 4);
    n = 4;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (an !== 4'b1110 && n < 80);
    check("scan_wrap", n, 16);

    // Load gating
    do_load(6'd7, 3'd3);
    expect_disp("load7", 7, 3);
    check("load7_ones", {25'd0, disp[0]}, {25'd0, 7'b1111000});
    check("load7_tens", {25'd0, disp[1]}, {25'd0, BLANK});
    @(negedge clk);
    X = 6'd10;
    fxn = 3'd5;
    repeat (3) @(negedge clk);
    expect_disp("hold7", 7, 3);
    do_load(6'd10, 3'd5);
    expect_disp("load10", 10, 5);
    check("load10_tens", {25'd0, disp[1]}, {25'd0, 7'b1111001});
    check("load10_ones", {25'd0, disp[0]}, {25'd0, 7'b1000000});

    // Boundaries
`ifdef ALU_DISP_SIGNED_EN
    do_load(6'b111011, 3'b010);
    expect_disp("neg5", 59, 2);
    check("neg5_ones", {25'd0, disp[0]}, {25'd0, 7'b0010010});
    check("neg5_tens", {25'd0, disp[1]}, {25'd0, 7'b1111111});
    check("neg5_sign", {25'd0, disp[2]}, {25'd0, 7'b0111111});
    check("neg5_fxn", {25'd0, disp[3]}, {25'd0, 7'b0100100});
    do_load(6'b100000, 3'd0);
    expect_disp("neg32", 32, 0);
    check("neg32_tens", {25'd0, disp[1]}, {25'd0, 7'b0110000});
    check("neg32_ones", {25'd0, disp[0]}, {25'd0, 7'b0100100});
    check("neg32_sign", {25'd0, disp[2]}, {25'd0, 7'b0111111});
    do_load(6'b011111, 3'd7);
    expect_disp("pos31", 31, 7);
    check("pos31_tens", {25'd0, disp[1]}, {25'd0, 7'b0110000});
    check("pos31_ones", {25'd0, disp[0]}, {25'd0, 7'b1111001});
    check("pos31_sign", {25'd0, disp[2]}, {25'd0, BLANK});
`else
    do_load(6'b111111, 3'd7);
    expect_disp("u63", 63, 7);
    check("u63_tens", {25'd0, disp[1]}, {25'd0, 7'b0000010});
    check("u63_ones", {25'd0, disp[0]}, {25'd0, 7'b0110000});
    check("u63_sign", {25'd0, disp[2]}, {25'd0, BLANK});
    do_load(6'b100000, 3'd0);
    expect_disp("u32", 32, 0);
    check("u32_sign", {25'd0, disp[2]}, {25'd0, BLANK});
`endif

    // Random single-cycle loads
    repeat (12) begin
      rx = 6'($urandom_range(0, 63));
      rf = 3'($urandom_range(0, 7));
      do_load(rx, rf);
      expect_disp("rand", int'(rx), int'(rf));
    end

    // Load held high: last sampled value wins
    @(negedge clk);
    load = 1'b1;
    repeat (3) begin
      rx = 6'($urandom_range(0, 63));
      rf = 3'($urandom_range(0, 7));
      X = rx;
      fxn = rf;
      @(negedge clk);
    end
    load = 1'b0;
    X = ~rx;
    expect_disp("held", int'(rx), int'(rf));

    // Reset mid-scan while the sign digit is active, with load asserted
    do_load(6'd45, 3'd6);
    n = 0;
    @(negedge clk);
    while (an !== 4'b1011 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("midscan_timeout", 32'd0, 32'd1);
    rst = 1'b1;
    load = 1'b1;
    X = 6'd42;
    fxn = 3'd6;
    @(posedge clk);
    #1;
    check("mid_rst_an", {28'd0, an}, 32'h0000000e);
    check("mid_rst_seg", {25'd0, seg}, 32'h00000040);
    @(negedge clk);
    rst = 1'b0;
    load = 1'b0;
    count_until_leave_ones("mid_restart", 4);
    expect_disp("after_rst", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
